// File: rtl/pe2_ntt_ctrl_if.sv
// Control/address bundle between the NTT sequencer and its memories / butterfly unit.
// Latency: none (pure signal grouping).
// Backpressure: none; the sequencer free-runs once a transform is accepted.
interface pe2_ntt_ctrl_if #(
  parameter int N_LOG = 8
);
  logic             start;
  logic             mode;
  logic             busy;
  logic             done;
  logic [N_LOG-1:0] stage;
  logic             rd_en;
  logic [N_LOG-1:0] rd_addr_u;
  logic [N_LOG-1:0] rd_addr_v;
  logic [N_LOG-1:0] tw_addr;
  logic             pe_sel_ntt;
  logic             wr_en;
  logic [N_LOG-1:0] wr_addr_u;
  logic [N_LOG-1:0] wr_addr_v;

  // Controller side: takes start/mode, drives strobes and addresses.
  modport master (
    input  start, mode,
    output busy, done, stage, rd_en, rd_addr_u, rd_addr_v, tw_addr,
           pe_sel_ntt, wr_en, wr_addr_u, wr_addr_v
  );

  // Host/memory side.
  modport slave (
    output start, mode,
    input  busy, done, stage, rd_en, rd_addr_u, rd_addr_v, tw_addr,
           pe_sel_ntt, wr_en, wr_addr_u, wr_addr_v
  );
endinterface

// File: rtl/pe2_ntt_ctrl.sv
// Radix-2 NTT/INTT sequencer: issues N/2 butterflies per stage over N_LOG stages.
// Latency: rd_en one cycle after accepted start; wr_en trails rd_en by PE_LAT; done at 1+N_LOG*(N/2+PE_LAT).
// Backpressure: none; start is only sampled in IDLE, ignored while busy or in the DONE cycle.
module pe2_ntt_ctrl #(
  parameter int N_LOG  = 8,
  parameter int PE_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  pe2_ntt_ctrl_if.master bus
);

  localparam int                DW     = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [N_LOG-1:0]  J_LAST = N_LOG'((1 << (N_LOG - 1)) - 1);
  localparam logic [N_LOG-1:0]  S_LAST = N_LOG'(N_LOG - 1);
  localparam logic [DW-1:0]     D_LAST = DW'(PE_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [N_LOG-1:0] j_q, j_d;
  logic [N_LOG-1:0] stage_q, stage_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             sel_q, sel_d;

  logic [N_LOG-1:0] u_q, v_q, tw_q;
  logic [N_LOG-1:0] sh, twsh, span, grp, u_c, v_c, tw_c;
  logic             rd_en;

  logic             wen_pipe_q [PE_LAT];
  logic [N_LOG-1:0] wu_pipe_q  [PE_LAT];
  logic [N_LOG-1:0] wv_pipe_q  [PE_LAT];

  // State, counters and the latched mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      stage_q <= '0;
      dcnt_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state: issue N/2 butterflies, drain PE_LAT cycles, repeat per stage.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          j_d     = '0;
          stage_d = '0;
          sel_d   = bus.mode;
        end
      end
      ISSUE: begin
        if (j_q == J_LAST) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          j_d = j_q + N_LOG'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == D_LAST) begin
          if (stage_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + N_LOG'(1);
            j_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Butterfly addressing: forward spans shrink per stage, inverse spans grow.
  always_comb begin
    sh   = sel_q ? stage_q : (S_LAST - stage_q);
    twsh = sel_q ? (S_LAST - stage_q) : stage_q;
    span = N_LOG'(1) << sh;
    grp  = j_q >> sh;
    u_c  = ((grp << sh) << 1) | (j_q & (span - N_LOG'(1)));
    v_c  = u_c + span;
    tw_c = (N_LOG'(1) << twsh) + grp;
  end

  assign rd_en = (state_q == ISSUE);

  // Remember the last issued addresses so the buses are stable between bursts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_q  <= '0;
      v_q  <= '0;
      tw_q <= '0;
    end else if (rd_en) begin
      u_q  <= u_c;
      v_q  <= v_c;
      tw_q <= tw_c;
    end
  end

  // Write-back pipeline mirrors the butterfly datapath latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < PE_LAT; k++) begin
        wen_pipe_q[k] <= 1'b0;
        wu_pipe_q[k]  <= '0;
        wv_pipe_q[k]  <= '0;
      end
    end else begin
      wen_pipe_q[0] <= rd_en;
      wu_pipe_q[0]  <= rd_en ? u_c : u_q;
      wv_pipe_q[0]  <= rd_en ? v_c : v_q;
      for (int k = 1; k < PE_LAT; k++) begin
        wen_pipe_q[k] <= wen_pipe_q[k-1];
        wu_pipe_q[k]  <= wu_pipe_q[k-1];
        wv_pipe_q[k]  <= wv_pipe_q[k-1];
      end
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.stage      = stage_q;
  assign bus.rd_en      = rd_en;
  assign bus.rd_addr_u  = rd_en ? u_c  : u_q;
  assign bus.rd_addr_v  = rd_en ? v_c  : v_q;
  assign bus.tw_addr    = rd_en ? tw_c : tw_q;
  assign bus.pe_sel_ntt = sel_q;
  assign bus.wr_en      = wen_pipe_q[PE_LAT-1];
  assign bus.wr_addr_u  = wu_pipe_q[PE_LAT-1];
  assign bus.wr_addr_v  = wv_pipe_q[PE_LAT-1];

endmodule

// File: tb/tb_pe2_ntt_ctrl.sv
// Randomized bench for pe2_ntt_ctrl against a per-cycle expected trace built from the transform rules.
// Latency: checks every cycle of each run, sampled on the falling edge.
// Backpressure: n/a; start/mode noise is injected while the sequencer is busy.
module tb_pe2_ntt_ctrl;
  localparam int NL     = 3;
  localparam int PL     = 4;
  localparam int N      = 1 << NL;
  localparam int HALF   = N / 2;
  localparam int DONE_T = 1 + NL * (HALF + PL);
  localparam int TMAX   = DONE_T + 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;

  pe2_ntt_ctrl_if #(.N_LOG(NL)) bus ();

  pe2_ntt_ctrl #(.N_LOG(NL), .PE_LAT(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected trace, indexed by cycle offset from the accepting cycle.
  int er [TMAX], eu [TMAX], ev [TMAX], etw [TMAX], est [TMAX];
  int ew [TMAX], ewu[TMAX], ewv[TMAX];
  int last_u, last_v, last_tw;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic build_model(input bit m);
    for (int t = 0; t < TMAX; t++) begin
      er[t] = 0; eu[t] = 0; ev[t] = 0; etw[t] = 0; est[t] = 0;
      ew[t] = 0; ewu[t] = 0; ewv[t] = 0;
    end
    for (int s = 0; s < NL; s++) begin
      for (int j = 0; j < HALF; j++) begin
        int span, grp, u, tr;
        span = m ? (1 << s) : (1 << (NL - 1 - s));
        grp  = j / span;
        u    = grp * 2 * span + (j % span);
        tr   = 1 + s * (HALF + PL) + j;
        er[tr]  = 1;
        eu[tr]  = u;
        ev[tr]  = u + span;
        etw[tr] = m ? ((N >> (s + 1)) + grp) : ((1 << s) + grp);
        est[tr] = s;
        ew[tr + PL]  = 1;
        ewu[tr + PL] = u;
        ewv[tr + PL] = u + span;
      end
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"},  int'(bus.busy),       0);
    check({pfx, "_done"},  int'(bus.done),       0);
    check({pfx, "_rd_en"}, int'(bus.rd_en),      0);
    check({pfx, "_wr_en"}, int'(bus.wr_en),      0);
    check({pfx, "_stage"}, int'(bus.stage),      0);
    check({pfx, "_u"},     int'(bus.rd_addr_u),  0);
    check({pfx, "_v"},     int'(bus.rd_addr_v),  0);
    check({pfx, "_tw"},    int'(bus.tw_addr),    0);
    check({pfx, "_wu"},    int'(bus.wr_addr_u),  0);
    check({pfx, "_wv"},    int'(bus.wr_addr_v),  0);
    check({pfx, "_sel"},   int'(bus.pe_sel_ntt), 0);
  endtask

  // Entered in cycle 0 (between edges). smode: 0 quiet, 1 random start, 2 start held high.
  // Returns at the falling edge of the first IDLE cycle after done (or after an abort).
  task automatic do_run(input bit m, input int smode, input bit chain, input int abort_at);
    build_model(m);
    bus.start = 1'b1;
    bus.mode  = m;
    for (int t = 1; t <= DONE_T + 1; t++) begin
      @(posedge clk);
      #1;
      case (smode)
        1:       bus.start = 1'($urandom_range(0, 1));
        2:       bus.start = 1'b1;
        default: bus.start = 1'b0;
      endcase
      bus.mode = (smode != 0) ? 1'($urandom_range(0, 1)) : m;
      if (t == DONE_T + 1) bus.start = chain;
      if (t == abort_at) begin
        bus.start = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        rst = 1'b1;
        last_u = 0; last_v = 0; last_tw = 0;
        return;
      end
      @(negedge clk);
      if (er[t] != 0) begin
        last_u = eu[t]; last_v = ev[t]; last_tw = etw[t];
        check("stage", int'(bus.stage), est[t]);
      end
      check("rd_en", int'(bus.rd_en), er[t]);
      check("rd_u",  int'(bus.rd_addr_u), last_u);
      check("rd_v",  int'(bus.rd_addr_v), last_v);
      check("tw",    int'(bus.tw_addr),   last_tw);
      check("wr_en", int'(bus.wr_en), ew[t]);
      if (ew[t] != 0) begin
        check("wr_u", int'(bus.wr_addr_u), ewu[t]);
        check("wr_v", int'(bus.wr_addr_v), ewv[t]);
      end
      check("busy", int'(bus.busy), (t <= DONE_T) ? 1 : 0);
      check("done", int'(bus.done), (t == DONE_T) ? 1 : 0);
      if (t <= DONE_T) check("sel", int'(bus.pe_sel_ntt), int'(m));
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      bus.mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_busy",  int'(bus.busy),  0);
      check("idle_wr_en", int'(bus.wr_en), 0);
      check("idle_rd_en", int'(bus.rd_en), 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    last_u = 0; last_v = 0; last_tw = 0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);

    // Directed forward and inverse runs.
    do_run(1'b0, 0, 1'b0, 0);
    idle_cycles(1);
    do_run(1'b1, 0, 1'b0, 0);
    idle_cycles(2);

    // Start held high through busy and DONE, then taken again in the next IDLE.
    do_run(1'b0, 2, 1'b1, 0);
    do_run(1'b1, 0, 1'b0, 0);
    idle_cycles(1);

    // Reset during stage 1 issue, then a clean rerun.
    do_run(1'b0, 0, 1'b0, 11);
    idle_cycles(8);
    do_run(1'b0, 0, 1'b0, 0);
    idle_cycles(1);

    // Random modes with start/mode noise while busy.
    for (int r = 0; r < 8; r++) begin
      do_run(1'($urandom_range(0, 1)), 1, 1'b0, 0);
      idle_cycles($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
